// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: forwarding selects, load-use / long-op stalls, branch
// flush and a per-register busy scoreboard for multi-cycle FPU/crypto ops.
module hazard_scoreboard #(
  parameter int REG_AW = 3,
  parameter int LAT_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_AW-1:0]      Rs1D,
  input  logic [REG_AW-1:0]      Rs2D,
  input  logic [REG_AW-1:0]      RdD,
  input  logic [REG_AW-1:0]      Rs1E,
  input  logic [REG_AW-1:0]      Rs2E,
  input  logic [REG_AW-1:0]      RdE,
  input  logic                   ResultSrcE0,
  input  logic                   LongIssueE,
  input  logic [LAT_W-1:0]       LongLatE,
  input  logic                   LongDone,
  input  logic [REG_AW-1:0]      LongDoneRd,
  input  logic                   PCSrcE,
  input  logic                   RegwriteM,
  input  logic                   RegwriteW,
  input  logic [REG_AW-1:0]      RdM,
  input  logic [REG_AW-1:0]      RdW,
  output logic [1:0]             Forward_A_E,
  output logic [1:0]             Forward_B_E,
  output logic                   StallF,
  output logic                   StallD,
  output logic                   FlushD,
  output logic                   FlushE,
  output logic [2**REG_AW-1:0]   busy_vec
);

  localparam int NREG = 2**REG_AW;

  logic [NREG-1:0]  r_busy;
  logic [LAT_W-1:0] r_cnt [NREG];

  logic [LAT_W-1:0] w_lat_eff;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;
  logic             w_lw_stall;
  logic             w_issue_stall;
  logic             w_sb_stall;
  logic             w_stall;

  // M stage has the younger value, so it wins over W.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                         input logic wr_m, input logic [REG_AW-1:0] rd_m,
                                         input logic wr_w, input logic [REG_AW-1:0] rd_w);
    if (wr_m && (rd_m != '0) && (rd_m == src))
      return 2'b10;
    else if (wr_w && (rd_w != '0) && (rd_w == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // A zero-latency request still needs one cycle of busy.
  assign w_lat_eff = (LongLatE == '0) ? LAT_W'(1) : LongLatE;

  // Hazard detection for the D-stage instruction.
  always_comb begin
    w_fwd_a       = fwd_sel(Rs1E, RegwriteM, RdM, RegwriteW, RdW);
    w_fwd_b       = fwd_sel(Rs2E, RegwriteM, RdM, RegwriteW, RdW);
    w_lw_stall    = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    // Covers the issue cycle itself, before the busy bit is registered.
    w_issue_stall = LongIssueE && (RdE != '0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D) || (RdE == RdD));
    w_sb_stall    = ((Rs1D != '0) && r_busy[Rs1D]) ||
                    ((Rs2D != '0) && r_busy[Rs2D]) ||
                    ((RdD  != '0) && r_busy[RdD]);
    w_stall       = w_lw_stall || w_issue_stall || w_sb_stall;
  end

  // All outputs are forced low while reset is held.
  assign Forward_A_E = rst ? 2'b00 : w_fwd_a;
  assign Forward_B_E = rst ? 2'b00 : w_fwd_b;
  assign StallF      = rst ? 1'b0  : w_stall;
  assign StallD      = rst ? 1'b0  : w_stall;
  assign FlushE      = rst ? 1'b0  : (w_stall || PCSrcE);
  assign FlushD      = rst ? 1'b0  : PCSrcE;
  assign busy_vec    = r_busy;

  // Per-register scoreboard: issue beats done, done beats expiry/countdown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      for (int r = 0; r < NREG; r++)
        r_cnt[r] <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (LongIssueE && !PCSrcE && (RdE == REG_AW'(r))) begin
          r_busy[r] <= 1'b1;
          r_cnt[r]  <= w_lat_eff;
        end else if (LongDone && (LongDoneRd == REG_AW'(r))) begin
          r_busy[r] <= 1'b0;
          r_cnt[r]  <= '0;
        end else if (r_busy[r] && (r_cnt[r] == LAT_W'(1))) begin
          r_busy[r] <= 1'b0;
          r_cnt[r]  <= '0;
        end else if (r_busy[r]) begin
          r_cnt[r]  <= r_cnt[r] - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard with a remaining-cycles model.
module tb_hazard_scoreboard;
  localparam int AW = 3;
  localparam int LW = 4;
  localparam int NR = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, LongDoneRd, RdM, RdW;
  logic          ResultSrcE0, LongIssueE, LongDone, PCSrcE, RegwriteM, RegwriteW;
  logic [LW-1:0] LongLatE;
  logic [1:0]    Forward_A_E, Forward_B_E;
  logic          StallF, StallD, FlushD, FlushE;
  logic [NR-1:0] busy_vec;
  logic [15:0]   obs;

  int total = 0;
  int bad   = 0;
  int rem [NR];   // cycles of busy left per register; busy == rem > 0

  hazard_scoreboard #(.REG_AW(AW), .LAT_W(LW)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE0(ResultSrcE0), .LongIssueE(LongIssueE), .LongLatE(LongLatE),
    .LongDone(LongDone), .LongDoneRd(LongDoneRd), .PCSrcE(PCSrcE),
    .RegwriteM(RegwriteM), .RegwriteW(RegwriteW), .RdM(RdM), .RdW(RdW),
    .Forward_A_E(Forward_A_E), .Forward_B_E(Forward_B_E),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  assign obs = {Forward_A_E, Forward_B_E, StallF, StallD, FlushD, FlushE, busy_vec};

  function automatic logic [1:0] m_fwd(input logic [AW-1:0] x);
    if (RegwriteM && RdM != 0 && RdM == x) return 2'b10;
    if (RegwriteW && RdW != 0 && RdW == x) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [NR-1:0] m_busy();
    logic [NR-1:0] v;
    for (int r = 0; r < NR; r++) v[r] = (rem[r] > 0);
    return v;
  endfunction

  function automatic logic m_stall();
    logic lw, iss, sb;
    lw  = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    iss = LongIssueE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D || RdE == RdD);
    sb  = (Rs1D != 0 && rem[Rs1D] > 0) || (Rs2D != 0 && rem[Rs2D] > 0) ||
          (RdD != 0 && rem[RdD] > 0);
    return lw || iss || sb;
  endfunction

  function automatic logic [15:0] m_outs();
    logic s;
    if (rst) return 16'h0000;
    s = m_stall();
    return {m_fwd(Rs1E), m_fwd(Rs2E), s, s, PCSrcE, s || PCSrcE, m_busy()};
  endfunction

  task automatic model_update();
    if (rst) begin
      for (int r = 0; r < NR; r++) rem[r] = 0;
    end else begin
      for (int r = 1; r < NR; r++) begin
        if (LongIssueE && !PCSrcE && RdE == r)
          rem[r] = (LongLatE == 0) ? 1 : int'(LongLatE);
        else if (LongDone && LongDoneRd == r)
          rem[r] = 0;
        else if (rem[r] > 0)
          rem[r] = rem[r] - 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; RdD = 0; Rs1E = 0; Rs2E = 0; RdE = 0;
    ResultSrcE0 = 0; LongIssueE = 0; LongLatE = 0; LongDone = 0; LongDoneRd = 0;
    PCSrcE = 0; RegwriteM = 0; RegwriteW = 0; RdM = 0; RdW = 0;
  endtask

  task automatic test_reset();
    for (int r = 0; r < NR; r++) rem[r] = 0;
    rst = 1'b1;
    clear_inputs();
    RegwriteM = 1; RdM = 3; Rs1E = 3; PCSrcE = 1; ResultSrcE0 = 1; RdE = 2; Rs1D = 2;
    #2;
    total++;
    if (obs !== 16'h0000) begin bad++; $display("FAIL reset_outs got=%h want=0000", obs); end
    tick();
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    total++;
    if (obs !== 16'h0000) begin bad++; $display("FAIL post_reset got=%h want=0000", obs); end
    tick();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    RegwriteM = 1; RegwriteW = 1; RdM = 3; RdW = 3; Rs1E = 3;
    @(negedge clk);
    total++;
    if (Forward_A_E !== 2'b10) begin bad++; $display("FAIL fwd_m got=%b want=10", Forward_A_E); end
    RegwriteM = 0;
    #1;
    total++;
    if (Forward_A_E !== 2'b01) begin bad++; $display("FAIL fwd_w got=%b want=01", Forward_A_E); end
    Rs1E = 0;
    #1;
    total++;
    if (Forward_A_E !== 2'b00) begin bad++; $display("FAIL fwd_zero got=%b want=00", Forward_A_E); end
    RegwriteM = 1; RdM = 6; RdW = 5; Rs2E = 6; Rs1E = 5;
    #1;
    total++;
    if ({Forward_A_E, Forward_B_E} !== 4'b0110) begin
      bad++; $display("FAIL fwd_ab got=%b want=0110", {Forward_A_E, Forward_B_E});
    end
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    ResultSrcE0 = 1; RdE = 2; Rs2D = 2;
    @(negedge clk);
    total++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b1101) begin
      bad++; $display("FAIL load_use got=%b want=1101", {StallF, StallD, FlushD, FlushE});
    end
    RdE = 0;
    #1;
    total++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b0000) begin
      bad++; $display("FAIL load_use_r0 got=%b want=0000", {StallF, StallD, FlushD, FlushE});
    end
    tick();
  endtask

  task automatic test_countdown();
    clear_inputs();
    Rs1D = 5; LongIssueE = 1; RdE = 5; LongLatE = 3;
    @(negedge clk);
    total++;
    if (StallD !== 1'b1 || FlushE !== 1'b1) begin
      bad++; $display("FAIL issue_stall got=%b%b want=11", StallD, FlushE);
    end
    tick();
    LongIssueE = 0; RdE = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (busy_vec[5] !== 1'b1 || StallD !== 1'b1) begin
        bad++; $display("FAIL countdown_busy cyc=%0d got=%b%b want=11", i, busy_vec[5], StallD);
      end
      tick();
    end
    @(negedge clk);
    total++;
    if (busy_vec[5] !== 1'b0 || StallD !== 1'b0) begin
      bad++; $display("FAIL countdown_expire got=%b%b want=00", busy_vec[5], StallD);
    end
    tick();
  endtask

  task automatic test_early_done();
    clear_inputs();
    LongIssueE = 1; RdE = 4; LongLatE = 10;
    tick();
    clear_inputs();
    @(negedge clk);
    total++;
    if (busy_vec[4] !== 1'b1) begin bad++; $display("FAIL early_busy got=%b want=1", busy_vec[4]); end
    tick();
    LongDone = 1; LongDoneRd = 4;
    @(negedge clk);
    total++;
    if (busy_vec[4] !== 1'b1) begin bad++; $display("FAIL done_cycle got=%b want=1", busy_vec[4]); end
    tick();
    clear_inputs();
    @(negedge clk);
    total++;
    if (busy_vec[4] !== 1'b0) begin bad++; $display("FAIL early_done got=%b want=0", busy_vec[4]); end
    LongIssueE = 1; RdE = 6; LongLatE = 2; LongDone = 1; LongDoneRd = 6;
    tick();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (busy_vec[6] !== ((i < 2) ? 1'b1 : 1'b0)) begin
        bad++; $display("FAIL issue_vs_done cyc=%0d got=%b want=%b", i, busy_vec[6], (i < 2));
      end
      tick();
    end
  endtask

  task automatic test_branch_waw();
    int n;
    clear_inputs();
    PCSrcE = 1; LongIssueE = 1; RdE = 7; LongLatE = 5;
    @(negedge clk);
    total++;
    if (FlushD !== 1'b1 || FlushE !== 1'b1) begin
      bad++; $display("FAIL branch_flush got=%b%b want=11", FlushD, FlushE);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    total++;
    if (busy_vec[7] !== 1'b0) begin bad++; $display("FAIL branch_no_issue got=%b want=0", busy_vec[7]); end
    LongIssueE = 1; RdE = 2; LongLatE = 4;
    tick();
    clear_inputs();
    RdD = 2;
    @(negedge clk);
    total++;
    if ({StallF, StallD, FlushE} !== 3'b111) begin
      bad++; $display("FAIL waw_stall got=%b want=111", {StallF, StallD, FlushE});
    end
    RdD = 0;
    n = 0;
    while (m_busy() != 0 && n < 20) begin tick(); n++; end
    @(negedge clk);
    total++;
    if (busy_vec !== 8'h00) begin bad++; $display("FAIL drain got=%h want=00", busy_vec); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      Rs1D = AW'($urandom_range(0, 7)); Rs2D = AW'($urandom_range(0, 7));
      RdD  = AW'($urandom_range(0, 7)); Rs1E = AW'($urandom_range(0, 7));
      Rs2E = AW'($urandom_range(0, 7)); RdE  = AW'($urandom_range(0, 7));
      RdM  = AW'($urandom_range(0, 7)); RdW  = AW'($urandom_range(0, 7));
      LongDoneRd  = AW'($urandom_range(0, 7));
      LongLatE    = LW'($urandom_range(0, 15));
      ResultSrcE0 = ($urandom_range(0, 3) == 0);
      LongIssueE  = ($urandom_range(0, 2) == 0);
      LongDone    = ($urandom_range(0, 5) == 0);
      PCSrcE      = ($urandom_range(0, 7) == 0);
      RegwriteM   = $urandom_range(0, 1) != 0;
      RegwriteW   = $urandom_range(0, 1) != 0;
      @(negedge clk);
      total++;
      if (obs !== m_outs()) begin
        bad++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs, m_outs());
      end
      tick();
    end
  endtask

  task automatic test_reset_midop();
    clear_inputs();
    LongIssueE = 1; RdE = 1; LongLatE = 9;
    tick();
    RdE = 3; LongLatE = 12;
    tick();
    clear_inputs();
    Rs1D = 1;
    @(negedge clk);
    total++;
    if (busy_vec[1] !== 1'b1 || busy_vec[3] !== 1'b1 || StallD !== 1'b1) begin
      bad++; $display("FAIL midop_busy got=%b%b%b want=111", busy_vec[1], busy_vec[3], StallD);
    end
    #2;
    rst = 1'b1;
    RegwriteM = 1; RdM = 3; Rs1E = 3; PCSrcE = 1;
    for (int r = 0; r < NR; r++) rem[r] = 0;
    #1;
    total++;
    if (obs !== 16'h0000) begin bad++; $display("FAIL midop_reset got=%h want=0000", obs); end
    tick();
    rst = 1'b0;
    clear_inputs();
    Rs1D = 1; Rs2D = 3; RdD = 3;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      total++;
      if (StallD !== 1'b0 || busy_vec !== 8'h00) begin
        bad++; $display("FAIL post_midop cyc=%0d got=%b/%h want=0/00", i, StallD, busy_vec);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_countdown();
    test_early_done();
    test_branch_waw();
    test_random();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Successor to the pipeline's forwarding-only hazard unit. Generalises it in register-address width and adds load-use stall, branch flush, and a per-register scoreboard.
- The scoreboard tracks destinations of multi-cycle FPU/crypto ops issued from E. Any D-stage instruction that reads or rewrites a pending register is stalled until the result is complete.
- Sits beside the 5-stage datapath and drives forwarding muxes, F/D stall enables and D/E flush.

Parameters:
- REG_AW, 3, register-address width; register file holds 2**REG_AW entries and register 0 is hardwired zero.
- LAT_W, 4, width of the per-register latency counter; maximum long-op latency is 2**LAT_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- Rs1D, Rs2D, RdD  in  REG_AW  sources and destination of the instruction in D.
- Rs1E, Rs2E, RdE  in  REG_AW  sources and destination of the instruction in E.
- ResultSrcE0  in  1  instruction in E is a load.
- LongIssueE  in  1  instruction in E is a multi-cycle op issuing this cycle.
- LongLatE  in  LAT_W  latency of that op in cycles; 0 is treated as 1.
- LongDone  in  1  long unit reports completion this cycle.
- LongDoneRd  in  REG_AW  destination register of the completing op.
- PCSrcE  in  1  branch or jump taken in E.
- RegwriteM, RegwriteW  in  1  register write enables in M and W.
- RdM, RdW  in  REG_AW  destinations in M and W.
- Forward_A_E, Forward_B_E  out  2  forwarding selects: 00 = register file, 10 = M, 01 = W.
- StallF, StallD  out  1  hold the PC and the F/D register.
- FlushD, FlushE  out  1  bubble the F/D and D/E registers.
- busy_vec  out  2**REG_AW  scoreboard busy bits; bit 0 is always 0.

Behaviour:
- Reset:
  - rst high clears all busy bits and counters immediately.
  - While rst is high every output is 0, including forwarding selects and stall/flush.
- Forwarding (combinational), per source X in {Rs1E, Rs2E}:
  - Select 10 if RegwriteM and RdM != 0 and RdM == X.
  - Otherwise select 01 if RegwriteW and RdW != 0 and RdW == X.
  - Otherwise 00. M takes priority over W.
- Hit definition: srcHit(r) = r != 0 and (r == Rs1D or r == Rs2D). dstHit(r) adds r == RdD (WAW).
- lwStall = ResultSrcE0 and srcHit(RdE).
- issueStall = LongIssueE and dstHit(RdE). This covers the issue cycle, before the busy bit is visible.
- sbStall = any source or destination in D (non-zero) whose busy bit is set.
- stall = lwStall or issueStall or sbStall.
- Outputs:
  - StallF = StallD = stall.
  - FlushE = stall or PCSrcE.
  - FlushD = PCSrcE.
  - On PCSrcE the D instruction is discarded, so the stall is moot; FlushD dominates.
- Scoreboard, per register r != 0, evaluated at each rising edge, highest priority first:
  1. Issue: LongIssueE and not PCSrcE and RdE == r and r != 0. Set busy = 1 and cnt = max(LongLatE, 1). Issue wins over a same-cycle done or expiry on r.
  2. Done: LongDone and LongDoneRd == r. Set busy = 0 and cnt = 0.
  3. Expiry: busy and cnt == 1. Set busy = 0 and cnt = 0.
  4. Countdown: busy and cnt > 1. Set cnt = cnt - 1.
- Busy timing: busy is visible from the cycle after the issue edge and stays high for exactly L cycles unless LongDone clears it earlier.
- Re-issue to a busy register overwrites the counter. It cannot occur in normal flow because of the WAW stall.
- Ignored events: LongIssueE with RdE == 0 does nothing. LongDone naming an idle register or register 0 does nothing.
- Multiple registers may be busy simultaneously, each with an independent counter.
- Reset mid-operation abandons all pending entries; there are no late clears after rst deasserts.

Test Plan:
- Forwarding priority: RegwriteM = RegwriteW = 1, RdM = RdW = Rs1E = 3 -> Forward_A_E = 10. Drop RegwriteM -> 01. Set Rs1E = 0 -> 00.
- Load-use: ResultSrcE0 = 1, RdE = 2, Rs2D = 2 -> StallF = StallD = FlushE = 1, FlushD = 0. Repeat with RdE = 0 -> all 0.
- Scoreboard countdown: issue LongIssueE with RdE = 5, LongLatE = 3; D holds Rs1D = 5 throughout.
  - Issue cycle: stall = 1.
  - Next 3 cycles: busy_vec[5] = 1.
  - 4th cycle after the edge: busy_vec[5] = 0 and stall = 0.
- Early done and simultaneity:
  - Issue RdE = 4 with LongLatE = 10, then pulse LongDone with LongDoneRd = 4 two cycles later -> busy_vec[4] clears at the next edge.
  - Same-cycle issue and done on register 6 -> busy_vec[6] = 1.
- Branch: PCSrcE = 1 together with LongIssueE, RdE = 7 -> FlushD = FlushE = 1 and busy_vec[7] stays 0. Also check WAW: RdD matching a busy register -> stall.
- Reset mid-op: busy registers 1 and 3 with counters running, assert rst asynchronously between edges -> busy_vec = 0 and all outputs 0 immediately. After release, no stall until a new issue.
